// File: rtl/uop_buf_if.sv
// Handshake bundle between the uop buffer controller and its decoder/fetch neighbours.
// Optional almost_full flag is present only when UOP_BUF_ALMOST_FULL_EN is defined.
interface uop_buf_if #(
  parameter int UOP_BUF_SIZE = 8
);
  localparam int AW = $clog2(UOP_BUF_SIZE);

  logic          wr_valid;
  logic          wr_ready;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   occupancy;
`ifdef UOP_BUF_ALMOST_FULL_EN
  logic          almost_full;
`endif

  // master: decoder/fetch side; slave: the buffer controller
  modport master (
    output wr_valid,
    output rd_ready,
    input  wr_ready,
    input  buf_wr_en,
    input  buf_wr_addr,
    input  rd_valid,
    input  rd_addr,
`ifdef UOP_BUF_ALMOST_FULL_EN
    input  almost_full,
`endif
    input  occupancy
  );

  modport slave (
    input  wr_valid,
    input  rd_ready,
    output wr_ready,
    output buf_wr_en,
    output buf_wr_addr,
    output rd_valid,
    output rd_addr,
`ifdef UOP_BUF_ALMOST_FULL_EN
    output almost_full,
`endif
    output occupancy
  );
endinterface

// File: rtl/uop_buf_ctrl.sv
// Pointer/occupancy controller for the circular uop buffer between decode and uop fetch.
// Define UOP_BUF_ALMOST_FULL_EN to add the registered almost_full flag.
module uop_buf_ctrl #(
  parameter int UOP_BUF_SIZE = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clear,
  uop_buf_if.slave bus
);
  localparam int AW = $clog2(UOP_BUF_SIZE);
  localparam int CW = AW + 1;

  if (UOP_BUF_SIZE < 4 || (UOP_BUF_SIZE & (UOP_BUF_SIZE - 1)) != 0) begin : g_bad_size
    $error("uop_buf_ctrl: UOP_BUF_SIZE must be a power of two >= 4");
  end

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_nxt;
  logic          wr_acc;
  logic          rd_acc;

  // Both handshake readies come from registered occupancy only
  assign bus.wr_ready    = (occ != CW'(UOP_BUF_SIZE));
  assign bus.rd_valid    = (occ != '0);
  assign bus.buf_wr_addr = wr_ptr;
  assign bus.rd_addr     = rd_ptr;
  assign bus.occupancy   = occ;

  assign wr_acc        = bus.wr_valid && bus.wr_ready && !clear;
  assign rd_acc        = bus.rd_valid && bus.rd_ready && !clear;
  assign bus.buf_wr_en = wr_acc;

  always_comb begin
    occ_nxt = occ;
    case ({wr_acc, rd_acc})
      2'b10:   occ_nxt = occ + CW'(1);
      2'b01:   occ_nxt = occ - CW'(1);
      default: occ_nxt = occ;
    endcase
  end

  // Power-of-two size lets the pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      occ <= occ_nxt;
    end
  end

`ifdef UOP_BUF_ALMOST_FULL_EN
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bus.almost_full <= 1'b0;
    end else begin
      bus.almost_full <= (occ_nxt >= CW'(UOP_BUF_SIZE - 2));
    end
  end
`endif

endmodule

// File: tb/tb_uop_buf_ctrl.sv
// Scoreboard bench for uop_buf_ctrl: write indices are queued on accept and matched on read.
module tb_uop_buf_ctrl;
  localparam int SIZE = 8;
  localparam int AW   = $clog2(SIZE);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;

  uop_buf_if #(.UOP_BUF_SIZE(SIZE)) bus ();

  uop_buf_ctrl #(.UOP_BUF_SIZE(SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  int m_wr  = 0;
  int m_rd  = 0;
  int m_occ = 0;
  int m_af  = 0;
  int sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_wr  = 0;
    m_rd  = 0;
    m_occ = 0;
    m_af  = 0;
    sb.delete();
  endtask

  // Drive one cycle, check outputs at the falling edge, then advance the model
  task automatic step(input logic wv, input logic rr, input logic clr);
    logic w_acc;
    logic r_acc;
    int   got;
    bus.wr_valid = wv;
    bus.rd_ready = rr;
    clear        = clr;
    @(negedge clk);
    w_acc = wv && (m_occ != SIZE) && !clr;
    r_acc = rr && (m_occ != 0) && !clr;
    chk("wr_ready",    32'(bus.wr_ready),    32'(m_occ != SIZE));
    chk("rd_valid",    32'(bus.rd_valid),    32'(m_occ != 0));
    chk("buf_wr_en",   32'(bus.buf_wr_en),   32'(w_acc));
    chk("buf_wr_addr", 32'(bus.buf_wr_addr), 32'(m_wr));
    chk("rd_addr",     32'(bus.rd_addr),     32'(m_rd));
    chk("occupancy",   32'(bus.occupancy),   32'(m_occ));
`ifdef UOP_BUF_ALMOST_FULL_EN
    chk("almost_full", 32'(bus.almost_full), 32'(m_af));
`endif
    if (w_acc) sb.push_back(m_wr);
    if (r_acc) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        got = sb.pop_front();
        chk("sb_rd_index", 32'(bus.rd_addr), 32'(got));
      end
    end
    @(posedge clk);
    #1;
    if (clr) begin
      model_zero();
    end else begin
      if (w_acc) m_wr = (m_wr + 1) % SIZE;
      if (r_acc) m_rd = (m_rd + 1) % SIZE;
      m_occ = m_occ + (w_acc ? 1 : 0) - (r_acc ? 1 : 0);
      m_af  = (m_occ >= SIZE - 2) ? 1 : 0;
    end
  endtask

  task automatic do_reset(input logic wv, input logic rr);
    bus.wr_valid = wv;
    bus.rd_ready = rr;
    clear        = 1'b0;
    reset        = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_zero();
    chk("rst_occ",     32'(bus.occupancy),   32'd0);
    chk("rst_wr_addr", 32'(bus.buf_wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(bus.rd_addr),     32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid),   32'd0);
    chk("rst_wr_ready", 32'(bus.wr_ready),   32'd1);
`ifdef UOP_BUF_ALMOST_FULL_EN
    chk("rst_af",      32'(bus.almost_full), 32'd0);
`endif
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(1'b0, 1'b0);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    @(negedge clk);
    chk("rst_buf_wr_en", 32'(bus.buf_wr_en), 32'd0);
    @(posedge clk);
    #1;

    // Fill to full, then a ninth offer that must be refused
    for (int i = 0; i < SIZE; i++) step(1'b1, 1'b0, 1'b0);
    chk("fill_occ",      32'(bus.occupancy), 32'd8);
    chk("fill_wr_ready", 32'(bus.wr_ready),  32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("ninth_occ",     32'(bus.occupancy), 32'd8);

    // Full with read and write together: read only, then wrap write to 0
    step(1'b1, 1'b1, 1'b0);
    chk("full_rw_occ",      32'(bus.occupancy),   32'd7);
    chk("full_rw_wr_ready", 32'(bus.wr_ready),    32'd1);
    chk("wrap_wr_addr",     32'(bus.buf_wr_addr), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
    chk("steady_occ",       32'(bus.occupancy),   32'd7);

    // Single write from empty; no bypass to the read side
    do_reset(1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    chk("lat_rd_valid", 32'(bus.rd_valid), 32'd1);
    chk("lat_rd_addr",  32'(bus.rd_addr),  32'd0);
    step(1'b0, 1'b1, 1'b0);
    chk("drain_occ",    32'(bus.occupancy), 32'd0);
    chk("drain_rd_ptr", 32'(bus.rd_addr),   32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    chk("empty_rd_ptr", 32'(bus.rd_addr),   32'd1);

    // Clear at occupancy 5 with both handshakes active
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    chk("clr_occ",      32'(bus.occupancy),   32'd0);
    chk("clr_wr_addr",  32'(bus.buf_wr_addr), 32'd0);
    chk("clr_rd_addr",  32'(bus.rd_addr),     32'd0);
    chk("clr_wr_ready", 32'(bus.wr_ready),    32'd1);

    // Streaming through: pointers wrap twice
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk("stream_occ_le1", 32'(bus.occupancy <= 1), 32'd1);
    end

`ifdef UOP_BUF_ALMOST_FULL_EN
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    chk("af_at6", 32'(bus.almost_full), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    chk("af_at5", 32'(bus.almost_full), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("af_at7", 32'(bus.almost_full), 32'd1);
`endif

    // Mid-operation reset with traffic offered
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    do_reset(1'b1, 1'b1);

    // Random traffic with occasional flushes
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) != 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uop_buf_ctrl.md
UOP_BUF_CTRL -- requirements
Module: uop_buf_ctrl

Interface
REQ-001 Parameter: UOP_BUF_SIZE, default UOP_BUF_SIZE from defines.inc (8), entry count of uop buffer, power of two, >=4 SHALL hold.
REQ-002 Port: clk  input  1  sole clock, all state on posedge SHALL update.
REQ-003 Port: reset  input  1  synchronous active-high reset SHALL be used.
REQ-004 Port: clear  input  1  pipeline flush, synchronous, SHALL empty buffer.
REQ-005 Port: wr_valid  input  1  decoder offers one instruction_bundle SHALL be indicated.
REQ-006 Port: wr_ready  output  1  controller can accept bundle SHALL be indicated.
REQ-007 Port: buf_wr_en  output  1  storage write strobe SHALL be driven.
REQ-008 Port: buf_wr_addr  output  $clog2(UOP_BUF_SIZE)  storage write index SHALL be driven.
REQ-009 Port: rd_valid  output  1  entry at rd_addr readable SHALL be indicated.
REQ-010 Port: rd_ready  input  1  fetch consumes entry (fetch not stalled) SHALL be sampled.
REQ-011 Port: rd_addr  output  $clog2(UOP_BUF_SIZE)  storage read index for uop_fetch SHALL be driven.
REQ-012 Port: occupancy  output  $clog2(UOP_BUF_SIZE)+1  valid entry count SHALL be driven.

Function
REQ-013 wr_ready SHALL equal (occupancy != UOP_BUF_SIZE) from registered state only, no combinational path from rd_ready.
REQ-014 Write accept = wr_valid && wr_ready && !clear; buf_wr_en SHALL equal write accept combinationally, buf_wr_addr = wr_ptr.
REQ-015 On write accept wr_ptr SHALL increment by 1 at next edge, modulo UOP_BUF_SIZE (wraps SIZE-1 -> 0).
REQ-016 rd_valid SHALL equal (occupancy != 0); rd_addr SHALL equal rd_ptr.
REQ-017 Read accept = rd_valid && rd_ready && !clear; rd_ptr SHALL increment modulo UOP_BUF_SIZE at next edge.
REQ-018 occupancy SHALL +1 on write-only accept, -1 on read-only accept, unchanged when both or neither.
REQ-019 Full with rd_ready high: write SHALL NOT be accepted that cycle; read proceeds; wr_ready rises next cycle.
REQ-020 Empty with wr_valid high: write accepted; rd_valid SHALL rise one cycle later (1-cycle write-to-read latency, no bypass).
REQ-021 rd_ready with rd_valid low SHALL be ignored; no pointer/count change, no underflow.
REQ-022 clear SHALL take priority over all writes/reads in same cycle: next edge wr_ptr=rd_ptr=0, occupancy=0; buf_wr_en low during clear cycle.
REQ-023 Storage contents SHALL NOT be modified by controller except through buf_wr_en.

Reset
REQ-024 reset SHALL take priority over clear and all handshakes.
REQ-025 After reset: wr_ptr=0, rd_ptr=0, occupancy=0, rd_valid=0, wr_ready=1, buf_wr_en=0, rd_addr=0, buf_wr_addr=0.
REQ-026 Reset asserted mid-operation SHALL discard all buffered entries identically to REQ-025 at next edge.

Configuration
REQ-027 Macro UOP_BUF_ALMOST_FULL_EN defined: extra output almost_full (1 bit) SHALL be present, registered, high when occupancy >= UOP_BUF_SIZE-2 after the edge's update, 0 after reset/clear.
REQ-028 Macro undefined: almost_full port SHALL be absent; all other behaviour identical.

Verification (UOP_BUF_SIZE=8)
REQ-029 Reset, then wr_valid=1, rd_ready=0 for 8 cycles -> occupancy 1..8, wr_ready=0 after 8th, 9th offer not accepted, buf_wr_addr 0..7.
REQ-030 Full, rd_ready=1, wr_valid=1 same cycle -> read accepted, write rejected, occupancy 7, next cycle write accepted at addr 0 (wrap), occupancy stays 7 with continued read.
REQ-031 Empty, single write cycle -> rd_valid=0 that cycle, 1 next cycle with rd_addr=0; rd_ready=1 -> occupancy back to 0, rd_ptr=1.
REQ-032 Occupancy 5, clear=1 with wr_valid=rd_ready=1 -> buf_wr_en=0, next cycle occupancy=0, rd_addr=0, buf_wr_addr=0, wr_ready=1.
REQ-033 20 cycles wr_valid=rd_ready=1 from empty -> pointers wrap past 7 to 0 twice, occupancy never exceeds 1, no lost or duplicated index.
REQ-034 UOP_BUF_ALMOST_FULL_EN defined: fill to 6 -> almost_full=1, read to 5 -> almost_full=0; reset at occupancy 7 -> almost_full=0 next cycle.
